// File: rtl/mem_lsu_pipe.sv
// Load/store unit between exe1 memory issue and the data cache: address generation,
// store alignment, cache handshake with timeout, load extension and a registered result.
module mem_lsu_pipe #(
  parameter int               ADDR_W  = 32,
  parameter int               RD_W    = 5,
  parameter int               EXP_W   = 7,
  parameter logic [EXP_W-1:0] EXP_ALE = 7'h09,
  parameter logic [EXP_W-1:0] EXP_TMO = 7'h3F,
  parameter int               TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_write,
  input  logic [1:0]        in_width,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_imm,
  input  logic [31:0]       in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              flush,
  output logic              cache_valid,
  output logic              cache_op,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [3:0]        cache_wstrb,
  output logic [31:0]       cache_wdata,
  input  logic              cache_addr_ok,
  input  logic              cache_data_ok,
  input  logic [31:0]       cache_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic [31:0]       out_data,
  output logic [EXP_W-1:0]  out_exp,
  output logic              stall,
  output logic [2:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the offering side holds its payload unchanged until that edge.
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_t;

  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_stale;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_op;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_wdata;
  logic [1:0]          r_width;
  logic                r_signed;
  logic [RD_W-1:0]     r_rd;
  logic [31:0]         r_data;
  logic [EXP_W-1:0]    r_exp;

  logic [ADDR_W-1:0]   w_ea;
  logic                w_accept;
  logic                w_misal;
  logic                w_data_ok;
  logic                w_tmo;
  logic                w_capture;
  logic                w_set_tmo;
  logic [3:0]          w_wstrb;
  logic [31:0]         w_wdata;
  logic [31:0]         w_ext;

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] w, input logic s);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (w)
      2'b00:   load_ext = {{24{s & b[7]}}, b};
      2'b01:   load_ext = {{16{s & h[15]}}, h};
      default: load_ext = d;
    endcase
  endfunction

  assign w_ea      = in_base + in_imm;
  assign w_accept  = in_valid & (r_state == S_IDLE);
  assign w_misal   = ((in_width == 2'b01) & w_ea[0]) | (in_width[1] & (w_ea[1:0] != 2'b00));
  // A data_ok owed to a flushed request must not complete a newer one.
  assign w_data_ok = cache_data_ok & ~r_stale;
  assign w_tmo     = (r_cnt == TMO_LAST);
  assign w_ext     = load_ext(cache_rdata, r_addr[1:0], r_width, r_signed);

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = in_wdata;
    case (in_width)
      2'b00: begin
        w_wstrb = 4'b0001 << w_ea[1:0];
        w_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << w_ea[1:0];
        w_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_set_tmo   = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_accept) w_state_nxt = ((in_exp != '0) | w_misal) ? S_RESP : S_REQ;
      S_REQ:
        if (cache_addr_ok) begin
          if (w_data_ok) begin
            w_state_nxt = S_RESP;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      S_WAIT:
        if (w_data_ok) begin
          w_state_nxt = S_RESP;
          w_capture   = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt = S_RESP;
          w_set_tmo   = 1'b1;
        end
      S_RESP:
        if (out_ready) w_state_nxt = S_IDLE;
      S_DRAIN:
        if (w_data_ok | w_tmo) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // An address already taken by the cache still owes a data_ok, so drain it.
    if (flush)
      w_state_nxt = ((r_state == S_REQ) & cache_addr_ok & ~w_data_ok) ? S_DRAIN : S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stale <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if ((r_state == S_WAIT) | (r_state == S_DRAIN))
        r_cnt <= r_cnt + 1'b1;
      if (flush & ((r_state == S_WAIT) | (r_state == S_DRAIN)) & ~w_data_ok)
        r_stale <= 1'b1;
      else if (cache_data_ok)
        r_stale <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_op     <= 1'b0;
      r_wstrb  <= '0;
      r_wdata  <= '0;
      r_width  <= '0;
      r_signed <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_exp    <= '0;
    end else if (w_accept) begin
      r_addr   <= w_ea;
      r_op     <= in_write;
      r_wstrb  <= w_wstrb;
      r_wdata  <= w_wdata;
      r_width  <= in_width;
      r_signed <= in_signed;
      r_rd     <= in_write ? '0 : in_rd;
      r_data   <= '0;
      if (in_exp != '0)
        r_exp <= in_exp;
      else if (w_misal)
        r_exp <= EXP_ALE;
      else
        r_exp <= '0;
    end else if (w_capture) begin
      r_data <= r_op ? 32'h0 : w_ext;
    end else if (w_set_tmo) begin
      r_exp <= EXP_TMO;
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign cache_valid = (r_state == S_REQ);
  assign out_valid   = (r_state == S_RESP);
  assign stall       = (r_state != S_IDLE) & ~((r_state == S_RESP) & out_ready);
  assign cache_op    = r_op;
  assign cache_addr  = r_addr;
  assign cache_wstrb = r_wstrb;
  assign cache_wdata = r_wdata;
  assign out_rd      = r_rd;
  assign out_data    = r_data;
  assign out_exp     = r_exp;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_lsu_pipe.sv
// Directed bench for mem_lsu_pipe: drivers push expected results, a negedge monitor pops
// and compares on every out_valid/out_ready handoff.
module tb_mem_lsu_pipe;
  localparam int RD_W    = 5;
  localparam int EXP_W   = 7;
  localparam int TMO_CYC = 4;
  localparam int RES_W   = RD_W + 32 + EXP_W;
  localparam int NEVER   = 1000;

  logic        clk, rstn;
  logic        in_valid, in_ready, in_write, in_signed, flush;
  logic [1:0]  in_width;
  logic [31:0] in_base, in_imm, in_wdata;
  logic [4:0]  in_rd;
  logic [6:0]  in_exp;
  logic        cache_valid, cache_op, cache_addr_ok, cache_data_ok;
  logic [31:0] cache_addr, cache_wdata, cache_rdata;
  logic [3:0]  cache_wstrb;
  logic        out_valid, out_ready, stall;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [6:0]  out_exp;
  logic [2:0]  dbg_state;

  logic [RES_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_lsu_pipe #(.TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write), .in_width(in_width),
    .in_signed(in_signed), .in_base(in_base), .in_imm(in_imm), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_exp(in_exp), .flush(flush),
    .cache_valid(cache_valid), .cache_op(cache_op), .cache_addr(cache_addr),
    .cache_wstrb(cache_wstrb), .cache_wdata(cache_wdata), .cache_addr_ok(cache_addr_ok),
    .cache_data_ok(cache_data_ok), .cache_rdata(cache_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_exp(out_exp), .stall(stall), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_in_ready"},    in_ready, 1);
    chk({tag, "_cache_valid"}, cache_valid, 0);
    chk({tag, "_cache_op"},    cache_op, 0);
    chk({tag, "_cache_addr"},  cache_addr, 0);
    chk({tag, "_cache_wstrb"}, cache_wstrb, 0);
    chk({tag, "_cache_wdata"}, cache_wdata, 0);
    chk({tag, "_out_valid"},   out_valid, 0);
    chk({tag, "_out_result"},  {out_rd, out_data, out_exp}, 0);
    chk({tag, "_stall"},       stall, 0);
  endtask

  // scoreboard monitor
  logic             hold_prev = 1'b0;
  logic [RES_W-1:0] prev_res;
  always @(negedge clk) begin
    logic [RES_W-1:0] got;
    if (!rstn) begin
      hold_prev = 1'b0;
    end else begin
      got = {out_rd, out_data, out_exp};
      if (hold_prev && out_valid) chk("hold_stable", got, prev_res);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else chk("result", got, exp_q.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      prev_res  = got;
    end
  end

  // driver: offers one op and plays the cache side for it
  task automatic do_op(input logic wr, input logic [1:0] wd, input logic sg,
                       input logic [31:0] base, input logic [31:0] imm, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [6:0] iexp, input logic [31:0] rdata,
                       input int ao, input int dk, input logic req,
                       input logic [31:0] e_addr, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata, input logic [RES_W-1:0] e_res,
                       input logic push);
    tick;
    in_valid = 1; in_write = wr; in_width = wd; in_signed = sg; in_base = base;
    in_imm = imm; in_wdata = wdata; in_rd = rd; in_exp = iexp;
    @(negedge clk);
    chk("in_ready", in_ready, 1);
    if (push) exp_q.push_back(e_res);
    tick;
    in_valid = 0;
    if (!req) begin
      @(negedge clk);
      chk("no_cache_req", cache_valid, 0);
      chk("direct_resp", out_valid, 1);
    end else begin
      for (int i = 0; i < ao; i++) begin
        @(negedge clk);
        chk("req_held_valid", cache_valid, 1);
        chk("req_held_addr", cache_addr, e_addr);
        tick;
      end
      cache_addr_ok = 1; cache_data_ok = (dk == 0); cache_rdata = rdata;
      @(negedge clk);
      chk("req_valid", cache_valid, 1);
      chk("req_addr", cache_addr, e_addr);
      chk("req_op", cache_op, wr);
      if (wr) begin
        chk("req_wstrb", cache_wstrb, e_strb);
        chk("req_wdata", cache_wdata, e_wdata);
      end
      tick;
      cache_addr_ok = 0; cache_data_ok = 0;
      if (dk == 0) begin
        @(negedge clk);
        chk("min_latency", out_valid, 1);
      end else if (dk < NEVER) begin
        for (int i = 1; i < dk; i++) begin
          @(negedge clk);
          chk("wait_no_req", cache_valid, 0);
          tick;
        end
        cache_data_ok = 1;
        tick;
        cache_data_ok = 0;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!(in_ready && exp_q.size() == 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, (in_ready && exp_q.size() == 0), 1);
  endtask

  initial begin
    rstn = 0; in_valid = 0; in_write = 0; in_width = 0; in_signed = 0; in_base = 0;
    in_imm = 0; in_wdata = 0; in_rd = 0; in_exp = 0; flush = 0; cache_addr_ok = 0;
    cache_data_ok = 0; cache_rdata = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    tick;
    rstn = 1;

    // word load, addr_ok and data_ok together
    do_op(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 5'd3, 7'h0, 32'hDEADBEEF, 0, 0, 1,
          32'h1000, 4'hF, 32'h0, {5'd3, 32'hDEADBEEF, 7'h00}, 1);
    wait_done("t_word_load_done");
    // signed byte load, addr_ok delayed, data after a WAIT cycle
    do_op(0, 2'b00, 1, 32'h1000, 32'h3, 32'h0, 5'd1, 7'h0, 32'h80FFFF7F, 1, 2, 1,
          32'h1003, 4'h0, 32'h0, {5'd1, 32'hFFFFFF80, 7'h00}, 1);
    wait_done("t_sbyte_done");
    do_op(0, 2'b00, 0, 32'h1000, 32'h3, 32'h0, 5'd1, 7'h0, 32'h80FFFF7F, 0, 1, 1,
          32'h1003, 4'h0, 32'h0, {5'd1, 32'h00000080, 7'h00}, 1);
    wait_done("t_ubyte_done");
    // half store with negative offset
    do_op(1, 2'b01, 0, 32'h2010, 32'hFFFFFFF2, 32'h1234ABCD, 5'd7, 7'h0, 32'h0, 0, 1, 1,
          32'h2002, 4'b1100, 32'hABCDABCD, {5'd0, 32'h0, 7'h00}, 1);
    wait_done("t_hstore_done");
    // misaligned word load and upstream exception
    do_op(0, 2'b10, 0, 32'h1000, 32'h1, 32'h0, 5'd4, 7'h0, 32'h0, 0, 0, 0,
          32'h0, 4'h0, 32'h0, {5'd4, 32'h0, 7'h09}, 1);
    wait_done("t_misalign_done");
    do_op(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 5'd6, 7'h05, 32'h0, 0, 0, 0,
          32'h0, 4'h0, 32'h0, {5'd6, 32'h0, 7'h05}, 1);
    wait_done("t_inexp_done");
    // signed half load from upper lane
    do_op(0, 2'b01, 1, 32'h1000, 32'h2, 32'h0, 5'd2, 7'h0, 32'h80011234, 0, 0, 1,
          32'h1002, 4'h0, 32'h0, {5'd2, 32'hFFFF8001, 7'h00}, 1);
    wait_done("t_shalf_done");

    // timeout with out_ready held low for 3 cycles
    out_ready = 0;
    do_op(0, 2'b10, 0, 32'h3000, 32'h0, 32'h0, 5'd9, 7'h0, 32'h0, 0, NEVER, 1,
          32'h3000, 4'h0, 32'h0, {5'd9, 32'h0, 7'h3F}, 1);
    for (int i = 0; i < TMO_CYC; i++) begin
      @(negedge clk);
      chk("tmo_wait_no_valid", out_valid, 0);
      chk("tmo_wait_stall", stall, 1);
    end
    @(negedge clk);
    chk("tmo_resp_valid", out_valid, 1);
    chk("tmo_resp_stall", stall, 1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1;
    wait_done("t_timeout_done");

    // flush in WAIT, then a late data_ok
    do_op(0, 2'b10, 0, 32'h1008, 32'h0, 32'h0, 5'd8, 7'h0, 32'h0, 0, NEVER, 1,
          32'h1008, 4'h0, 32'h0, '0, 0);
    flush = 1;
    tick;
    flush = 0;
    @(negedge clk);
    chk("flush_idle", in_ready, 1);
    cache_data_ok = 1; cache_rdata = 32'h12345678;
    tick;
    cache_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_no_result", out_valid, 0);
    end
    do_op(0, 2'b10, 0, 32'h1000, 32'h4, 32'h0, 5'd10, 7'h0, 32'h0BADF00D, 0, 1, 1,
          32'h1004, 4'h0, 32'h0, {5'd10, 32'h0BADF00D, 7'h00}, 1);
    wait_done("t_after_flush_done");

    // reset pulsed while a request is outstanding
    tick;
    in_valid = 1; in_write = 1; in_width = 2'b10; in_base = 32'h1010; in_imm = 0;
    in_wdata = 32'hCAFEF00D; in_rd = 5'd1; in_exp = 0;
    tick;
    in_valid = 0;
    @(negedge clk);
    chk("rst_req_valid", cache_valid, 1);
    #1 rstn = 0;
    #1 chk_rst("midreset");
    tick;
    rstn = 1;

    // byte store after reset
    do_op(1, 2'b00, 0, 32'h1000, 32'h1, 32'h000000A5, 5'd5, 7'h0, 32'h0, 0, 0, 1,
          32'h1001, 4'b0010, 32'hA5A5A5A5, {5'd0, 32'h0, 7'h00}, 1);
    wait_done("t_bstore_done");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
